// File: rtl/mem_access_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_pkg
//  Description : Shared FSM encoding, byte-enable constants and lane helper
//                for the MEM pipeline stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } mem_state_t;

  localparam logic [3:0] BE_WORD  = 4'hF;
  localparam logic [3:0] BE_BYTE0 = 4'h1;

  function automatic logic [3:0] byte_enable(input logic byte_access, input logic [1:0] lane);
    return byte_access ? (BE_BYTE0 << lane) : BE_WORD;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_stage_if
//  Description : Valid/ready data-memory port between the MEM stage (master)
//                and the data memory (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_access_stage_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();

  logic                      mem_req;
  logic                      mem_ready;
  logic                      mem_wr;
  logic [ADDR_WIDTH-1:0]     mem_addr;
  logic [DATA_WIDTH-1:0]     mem_wdata;
  logic [DATA_WIDTH/8-1:0]   mem_be;
  logic                      mem_rvalid;
  logic [DATA_WIDTH-1:0]     mem_rdata;

  modport master (
    output mem_req, mem_wr, mem_addr, mem_wdata, mem_be,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_wr, mem_addr, mem_wdata, mem_be,
    output mem_ready, mem_rvalid, mem_rdata
  );

endinterface
`default_nettype wire

// File: rtl/mem_access_stage_load_align.sv
`default_nettype none
// ============================================================================
//  Module      : load_align
//  Description : Little-endian load alignment; byte loads are zero-extended.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_align (
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic        byte_access,
  output logic [31:0] aligned
);

  logic [7:0] w_lane;

  always_comb begin
    w_lane = 8'h00;
    case (addr)
      2'd0:    w_lane = rdata[7:0];
      2'd1:    w_lane = rdata[15:8];
      2'd2:    w_lane = rdata[23:16];
      default: w_lane = rdata[31:24];
    endcase
  end

  assign aligned = byte_access ? {24'h000000, w_lane} : rdata;

endmodule
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_stage
//  Description : MEM pipeline stage: issues loads/stores on a valid/ready
//                memory port, stalls upstream while busy, drives MEM/WB.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,

  input  logic                      ex_valid_in,
  input  logic                      reg_write_enable_in,
  input  logic                      mem_write_enable_in,
  input  logic                      mem_to_reg_select_in,
  input  logic                      byte_access_in,
  input  logic [DATA_WIDTH-1:0]     alu_result_in,
  input  logic [DATA_WIDTH-1:0]     store_data_in,
  input  logic [REG_ADDR_WIDTH-1:0] rd_in,

  output logic                      stall_out,

  mem_access_stage_if.master        mem,

  output logic                      wb_reg_write_enable,
  output logic                      wb_mem_to_reg_select,
  output logic [DATA_WIDTH-1:0]     wb_alu_result,
  output logic [DATA_WIDTH-1:0]     wb_mem_data,
  output logic [REG_ADDR_WIDTH-1:0] wb_rd,
  output logic                      misalign_err
);

  mem_state_t            r_state;
  logic                  r_byte_access;
  logic [1:0]            r_lane;

  logic                  w_mem_op;
  logic                  w_misaligned;
  logic                  w_start;
  logic                  w_store_done;
  logic                  w_load_done;
  logic                  w_wb_load;
  logic [DATA_WIDTH-1:0] w_aligned;
  logic [DATA_WIDTH-1:0] w_wdata;

  assign w_mem_op     = ex_valid_in & (mem_write_enable_in | mem_to_reg_select_in);
  assign w_misaligned = ~byte_access_in & (alu_result_in[1:0] != 2'b00);
  assign w_start      = (r_state == S_IDLE) & w_mem_op & ~w_misaligned;
  assign w_store_done = (r_state == S_REQ) & mem.mem_ready & mem.mem_wr;
  assign w_load_done  = (r_state == S_RESP) & mem.mem_rvalid;

  // MEM/WB takes real fields only when no transaction is holding the slot;
  // every other cycle (stall or misaligned access) it receives a bubble.
  assign w_wb_load = ((r_state == S_IDLE) & ~w_mem_op) | w_store_done | w_load_done;

  assign stall_out = w_start
                   | (r_state == S_REQ)
                   | ((r_state == S_RESP) & ~mem.mem_rvalid);

  assign w_wdata = byte_access_in ? {4{store_data_in[7:0]}} : store_data_in;

  load_align u_load_align (
    .rdata       (mem.mem_rdata),
    .addr        (r_lane),
    .byte_access (r_byte_access),
    .aligned     (w_aligned)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state              <= S_IDLE;
      r_byte_access        <= 1'b0;
      r_lane               <= 2'b00;
      mem.mem_req          <= 1'b0;
      mem.mem_wr           <= 1'b0;
      mem.mem_addr         <= '0;
      mem.mem_wdata        <= '0;
      mem.mem_be           <= '0;
      wb_reg_write_enable  <= 1'b0;
      wb_mem_to_reg_select <= 1'b0;
      wb_alu_result        <= '0;
      wb_mem_data          <= '0;
      wb_rd                <= '0;
      misalign_err         <= 1'b0;
    end else begin
      misalign_err <= (r_state == S_IDLE) & w_mem_op & w_misaligned;

      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state       <= S_REQ;
            r_byte_access <= byte_access_in;
            r_lane        <= alu_result_in[1:0];
            mem.mem_req   <= 1'b1;
            mem.mem_wr    <= mem_write_enable_in;
            mem.mem_addr  <= {alu_result_in[ADDR_WIDTH-1:2], 2'b00};
            mem.mem_wdata <= w_wdata;
            mem.mem_be    <= byte_enable(byte_access_in, alu_result_in[1:0]);
          end
        end
        S_REQ: begin
          if (mem.mem_ready) begin
            mem.mem_req <= 1'b0;
            r_state     <= mem.mem_wr ? S_IDLE : S_RESP;
          end
        end
        S_RESP: begin
          if (mem.mem_rvalid) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      wb_reg_write_enable  <= w_wb_load & reg_write_enable_in & ex_valid_in;
      wb_mem_to_reg_select <= w_wb_load & mem_to_reg_select_in & ex_valid_in;
      wb_alu_result        <= w_wb_load ? alu_result_in : '0;
      wb_rd                <= w_wb_load ? rd_in : '0;
      wb_mem_data          <= w_load_done ? w_aligned : '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_stage
//  Description : Directed self-checking bench for mem_access_stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ex_valid_in, reg_write_enable_in, mem_write_enable_in;
  logic        mem_to_reg_select_in, byte_access_in;
  logic [31:0] alu_result_in, store_data_in;
  logic [3:0]  rd_in;
  logic        stall_out;
  logic        wb_reg_write_enable, wb_mem_to_reg_select;
  logic [31:0] wb_alu_result, wb_mem_data;
  logic [3:0]  wb_rd;
  logic        misalign_err;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access_stage_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mem_bus ();

  mem_access_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .REG_ADDR_WIDTH(4)) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .ex_valid_in          (ex_valid_in),
    .reg_write_enable_in  (reg_write_enable_in),
    .mem_write_enable_in  (mem_write_enable_in),
    .mem_to_reg_select_in (mem_to_reg_select_in),
    .byte_access_in       (byte_access_in),
    .alu_result_in        (alu_result_in),
    .store_data_in        (store_data_in),
    .rd_in                (rd_in),
    .stall_out            (stall_out),
    .mem                  (mem_bus),
    .wb_reg_write_enable  (wb_reg_write_enable),
    .wb_mem_to_reg_select (wb_mem_to_reg_select),
    .wb_alu_result        (wb_alu_result),
    .wb_mem_data          (wb_mem_data),
    .wb_rd                (wb_rd),
    .misalign_err         (misalign_err)
  );

  always #5 clk = ~clk;

  task automatic drive_ex(input logic v, input logic rw, input logic mw, input logic m2r,
                          input logic b, input logic [31:0] alu, input logic [31:0] sd,
                          input logic [3:0] rd);
    ex_valid_in          = v;
    reg_write_enable_in  = rw;
    mem_write_enable_in  = mw;
    mem_to_reg_select_in = m2r;
    byte_access_in       = b;
    alu_result_in        = alu;
    store_data_in        = sd;
    rd_in                = rd;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    drive_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    mem_bus.mem_ready  = 1'b0;
    mem_bus.mem_rvalid = 1'b0;
    mem_bus.mem_rdata  = 32'h0;
    @(negedge clk); @(negedge clk);
    n_checks++;
    if ({mem_bus.mem_req, mem_bus.mem_wr, mem_bus.mem_be} !== 6'b0) begin
      n_fail++; $display("FAIL reset_mem_ctrl: got %b required 0", {mem_bus.mem_req, mem_bus.mem_wr, mem_bus.mem_be});
    end
    n_checks++;
    if ({mem_bus.mem_addr, mem_bus.mem_wdata} !== 64'h0) begin
      n_fail++; $display("FAIL reset_mem_bus: addr %h wdata %h required 0", mem_bus.mem_addr, mem_bus.mem_wdata);
    end
    n_checks++;
    if ({wb_reg_write_enable, wb_mem_to_reg_select, wb_alu_result, wb_mem_data, wb_rd} !== 70'h0) begin
      n_fail++; $display("FAIL reset_wb: we %b m2r %b alu %h md %h rd %h required 0",
                         wb_reg_write_enable, wb_mem_to_reg_select, wb_alu_result, wb_mem_data, wb_rd);
    end
    n_checks++;
    if ({stall_out, misalign_err} !== 2'b00) begin
      n_fail++; $display("FAIL reset_stall_err: got %b required 00", {stall_out, misalign_err});
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_alu_op;
    drive_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1234, 32'h0, 4'd3);
    #1;
    n_checks++;
    if (stall_out !== 1'b0 || mem_bus.mem_req !== 1'b0) begin
      n_fail++; $display("FAIL alu_no_stall: stall %b req %b required 0 0", stall_out, mem_bus.mem_req);
    end
    @(negedge clk);
    n_checks++;
    if (wb_rd !== 4'd3 || wb_alu_result !== 32'h1234 || wb_reg_write_enable !== 1'b1) begin
      n_fail++; $display("FAIL alu_wb: rd %0d alu %h we %b required 3 1234 1", wb_rd, wb_alu_result, wb_reg_write_enable);
    end
    n_checks++;
    if (stall_out !== 1'b0 || wb_mem_to_reg_select !== 1'b0) begin
      n_fail++; $display("FAIL alu_after: stall %b m2r %b required 0 0", stall_out, wb_mem_to_reg_select);
    end
    drive_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
  endtask

  task automatic test_word_store;
    int n_stall = 0;
    drive_ex(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 32'hDEADBEEF, 4'd1);
    for (int c = 0; c < 5; c++) begin
      mem_bus.mem_ready = (c == 4);
      #1;
      if (stall_out === 1'b1) n_stall++;
      if (c >= 1) begin
        n_checks++;
        if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_wr !== 1'b1 || mem_bus.mem_addr !== 32'h100 ||
            mem_bus.mem_be !== 4'hF || mem_bus.mem_wdata !== 32'hDEADBEEF) begin
          n_fail++; $display("FAIL wstore_bus c%0d: req %b wr %b addr %h be %h wdata %h required 1 1 100 f deadbeef",
                             c, mem_bus.mem_req, mem_bus.mem_wr, mem_bus.mem_addr, mem_bus.mem_be, mem_bus.mem_wdata);
        end
        n_checks++;
        if (wb_reg_write_enable !== 1'b0) begin
          n_fail++; $display("FAIL wstore_bubble c%0d: we %b required 0", c, wb_reg_write_enable);
        end
      end
      @(negedge clk);
    end
    drive_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    mem_bus.mem_ready = 1'b0;
    #1;
    if (stall_out === 1'b1) n_stall++;
    n_checks++;
    if (n_stall != 5) begin
      n_fail++; $display("FAIL wstore_stall_len: got %0d required 5", n_stall);
    end
    n_checks++;
    if (mem_bus.mem_req !== 1'b0 || wb_reg_write_enable !== 1'b0) begin
      n_fail++; $display("FAIL wstore_done: req %b we %b required 0 0", mem_bus.mem_req, wb_reg_write_enable);
    end
    @(negedge clk);
  endtask

  task automatic test_byte_load;
    int n_done = 0;
    drive_ex(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h203, 32'h0, 4'd5);
    @(negedge clk);
    mem_bus.mem_ready = 1'b1;
    #1;
    n_checks++;
    if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_wr !== 1'b0 || mem_bus.mem_addr !== 32'h200 || mem_bus.mem_be !== 4'b1000) begin
      n_fail++; $display("FAIL bload_req: req %b wr %b addr %h be %b required 1 0 200 1000",
                         mem_bus.mem_req, mem_bus.mem_wr, mem_bus.mem_addr, mem_bus.mem_be);
    end
    for (int c = 2; c < 4; c++) begin
      @(negedge clk);
      mem_bus.mem_ready  = 1'b0;
      mem_bus.mem_rvalid = (c == 3);
      mem_bus.mem_rdata  = (c == 3) ? 32'hAABBCCDD : 32'h0;
      #1;
      if (wb_reg_write_enable === 1'b1) n_done++;
      n_checks++;
      if (stall_out !== (c == 2)) begin
        n_fail++; $display("FAIL bload_stall c%0d: got %b required %b", c, stall_out, (c == 2));
      end
    end
    @(negedge clk);
    mem_bus.mem_rvalid = 1'b0;
    drive_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    n_checks++;
    if (wb_mem_data !== 32'h000000AA || wb_mem_to_reg_select !== 1'b1 ||
        wb_reg_write_enable !== 1'b1 || wb_rd !== 4'd5) begin
      n_fail++; $display("FAIL bload_wb: md %h m2r %b we %b rd %0d required 000000aa 1 1 5",
                         wb_mem_data, wb_mem_to_reg_select, wb_reg_write_enable, wb_rd);
    end
    @(negedge clk);
    if (wb_reg_write_enable === 1'b1) n_done++;
    n_checks++;
    if (n_done != 0) begin
      n_fail++; $display("FAIL bload_single: extra completions %0d required 0", n_done);
    end
  endtask

  task automatic test_byte_store;
    drive_ex(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h12, 32'h0000005A, 4'd0);
    @(negedge clk);
    mem_bus.mem_ready = 1'b1;
    #1;
    n_checks++;
    if (mem_bus.mem_be !== 4'b0100 || mem_bus.mem_wdata !== 32'h5A5A5A5A || mem_bus.mem_addr !== 32'h10) begin
      n_fail++; $display("FAIL bstore_lane: be %b wdata %h addr %h required 0100 5a5a5a5a 10",
                         mem_bus.mem_be, mem_bus.mem_wdata, mem_bus.mem_addr);
    end
    @(negedge clk);
    mem_bus.mem_ready = 1'b0;
    drive_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    n_checks++;
    if (mem_bus.mem_req !== 1'b0 || stall_out !== 1'b0) begin
      n_fail++; $display("FAIL bstore_done: req %b stall %b required 0 0", mem_bus.mem_req, stall_out);
    end
    @(negedge clk);
  endtask

  task automatic test_misalign;
    drive_ex(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h102, 32'h0, 4'd6);
    #1;
    n_checks++;
    if (stall_out !== 1'b0) begin
      n_fail++; $display("FAIL misalign_stall: got %b required 0", stall_out);
    end
    @(negedge clk);
    drive_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    n_checks++;
    if (misalign_err !== 1'b1 || mem_bus.mem_req !== 1'b0 || wb_reg_write_enable !== 1'b0) begin
      n_fail++; $display("FAIL misalign_pulse: err %b req %b we %b required 1 0 0",
                         misalign_err, mem_bus.mem_req, wb_reg_write_enable);
    end
    @(negedge clk);
    n_checks++;
    if (misalign_err !== 1'b0 || mem_bus.mem_req !== 1'b0) begin
      n_fail++; $display("FAIL misalign_width: err %b req %b required 0 0", misalign_err, mem_bus.mem_req);
    end
  endtask

  task automatic test_reset_in_resp;
    drive_ex(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 4'd2);
    @(negedge clk);
    mem_bus.mem_ready = 1'b1;
    @(negedge clk);
    mem_bus.mem_ready = 1'b0;
    #2;
    reset_n = 1'b0;
    drive_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    n_checks++;
    if (stall_out !== 1'b0 || mem_bus.mem_req !== 1'b0 || mem_bus.mem_addr !== 32'h0 || wb_reg_write_enable !== 1'b0) begin
      n_fail++; $display("FAIL rst_resp_clear: stall %b req %b addr %h we %b required 0 0 0 0",
                         stall_out, mem_bus.mem_req, mem_bus.mem_addr, wb_reg_write_enable);
    end
    @(negedge clk);
    reset_n = 1'b1;
    mem_bus.mem_rvalid = 1'b1;
    mem_bus.mem_rdata  = 32'hFFFFFFFF;
    #1;
    n_checks++;
    if (stall_out !== 1'b0) begin
      n_fail++; $display("FAIL rst_stray_stall: got %b required 0", stall_out);
    end
    @(negedge clk);
    mem_bus.mem_rvalid = 1'b0;
    n_checks++;
    if (wb_mem_data !== 32'h0 || wb_mem_to_reg_select !== 1'b0 || wb_reg_write_enable !== 1'b0) begin
      n_fail++; $display("FAIL rst_stray_wb: md %h m2r %b we %b required 0 0 0",
                         wb_mem_data, wb_mem_to_reg_select, wb_reg_write_enable);
    end
    drive_ex(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h80, 32'h0, 4'd7);
    @(negedge clk);
    mem_bus.mem_ready = 1'b1;
    @(negedge clk);
    mem_bus.mem_ready = 1'b0;
    @(negedge clk);
    mem_bus.mem_rvalid = 1'b1;
    mem_bus.mem_rdata  = 32'h11223344;
    @(negedge clk);
    mem_bus.mem_rvalid = 1'b0;
    drive_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    n_checks++;
    if (wb_mem_data !== 32'h11223344 || wb_rd !== 4'd7 || wb_reg_write_enable !== 1'b1) begin
      n_fail++; $display("FAIL rst_next_load: md %h rd %0d we %b required 11223344 7 1",
                         wb_mem_data, wb_rd, wb_reg_write_enable);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_alu_op();
    test_word_store();
    test_byte_load();
    test_byte_store();
    test_misalign();
    test_reset_in_resp();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
